// File: rtl/voltmeter_spi_pkg.sv
// Shared definitions for the voltmeter SPI link: FSM states, frame size and the
// bit layout of the status word returned by the slave.
package voltmeter_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
    } spi_state_e;

    localparam int unsigned FRAME_BITS   = 32;
    localparam int unsigned HALF_PERIODS = 2 * FRAME_BITS;

    localparam int unsigned STAT_COUNT_LSB    = 0;
    localparam int unsigned STAT_COUNT_MSB    = 15;
    localparam int unsigned STAT_COMP         = 16;
    localparam int unsigned STAT_SAT_HI       = 17;
    localparam int unsigned STAT_SAT_LO       = 18;
    localparam int unsigned STAT_REF_OK       = 19;
    localparam int unsigned STAT_AFE_SEL_LSB  = 20;
    localparam int unsigned STAT_AFE_SEL_MSB  = 21;
    localparam int unsigned STAT_RANGE_LSB    = 22;
    localparam int unsigned STAT_RANGE_MSB    = 24;
    localparam int unsigned STAT_AFE_RESET    = 25;
    localparam int unsigned STAT_REF_SIGN     = 26;
    localparam int unsigned STAT_RANGE_ERROR  = 27;
    localparam int unsigned STAT_DONE         = 28;
    localparam int unsigned STAT_COUNTER_DONE = 29;
    localparam int unsigned STAT_COUNTER_EN   = 30;
    localparam int unsigned STAT_OVERRIDE     = 31;

    function automatic logic [15:0] stat_count(input logic [FRAME_BITS-1:0] word);
        return word[STAT_COUNT_MSB:STAT_COUNT_LSB];
    endfunction

    function automatic logic [1:0] stat_afe_sel(input logic [FRAME_BITS-1:0] word);
        return word[STAT_AFE_SEL_MSB:STAT_AFE_SEL_LSB];
    endfunction

    function automatic logic [2:0] stat_range_sel(input logic [FRAME_BITS-1:0] word);
        return word[STAT_RANGE_MSB:STAT_RANGE_LSB];
    endfunction

    function automatic logic stat_bit(input logic [FRAME_BITS-1:0] word,
                                      input int unsigned          pos);
        return word[pos];
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK generator: half-period tick while enabled, SCLK toggling only while
// toggle_en_i is high, and single-cycle strobes on the cycle SCLK rises/falls.
module spi_sclk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic toggle_en_i,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam int unsigned          CntW   = $clog2(CLK_DIV);
    localparam logic [CntW-1:0]      CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            tick;

    always_comb begin
        tick   = en_i && (cnt_q == CntMax);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            if (toggle_en_i) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign tick_o = tick;
    assign rise_o = tick && toggle_en_i && !sclk_q;
    assign fall_o = tick && toggle_en_i && sclk_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master for 32-bit frames, started by start_i or by a synchronised
// slave interrupt edge when auto_en_i is set.
module spi_master
    import voltmeter_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] tx_data_i,
    input  logic                  auto_en_i,
    input  logic                  irq_i,
    output logic                  busy_o,
    output logic                  rx_dv_o,
    output logic [FRAME_BITS-1:0] rx_data_o,
    output logic                  spi_sclk_o,
    output logic                  spi_cs_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int unsigned        HpW     = $clog2(HALF_PERIODS);
    localparam logic [HpW-1:0]     HpLast  = HpW'(HALF_PERIODS - 1);
    localparam int unsigned        GapW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GapW-1:0]    GapLast = GapW'(CS_GAP - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_master: CLK_DIV must be at least 2");
    end
    if (CS_GAP < 1) begin : g_bad_gap
        $error("spi_master: CS_GAP must be at least 1");
    end

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-2:0] tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [HpW-1:0]        hp_cnt_q, hp_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                  irq_sync1_q, irq_sync2_q, irq_prev_q;
    logic                  irq_pend_q, irq_pend_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  rx_dv_q, rx_dv_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;

    logic                  div_en, div_toggle, tick, sclk_rise, sclk_fall;
    logic                  accept, irq_take, irq_edge;
    logic [FRAME_BITS-1:0] tx_word;

    spi_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (div_en),
        .toggle_en_i(div_toggle),
        .tick_o     (tick),
        .rise_o     (sclk_rise),
        .fall_o     (sclk_fall),
        .sclk_o     (spi_sclk_o)
    );

    assign div_en     = (state_q == StSetup) || (state_q == StXfer) || (state_q == StHold);
    assign div_toggle = (state_q == StXfer);

    // start_i has priority; an irq request stays pending until it can be served.
    assign accept   = (state_q == StIdle) && (start_i || irq_pend_q);
    assign irq_take = (state_q == StIdle) && !start_i && irq_pend_q;
    assign irq_edge = irq_sync2_q && !irq_prev_q;
    assign tx_word  = start_i ? tx_data_i : '0;

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        hp_cnt_d  = hp_cnt_q;
        gap_cnt_d = gap_cnt_q;
        mosi_d    = mosi_q;
        rx_dv_d   = 1'b0;
        rx_data_d = rx_data_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StSetup;
                    tx_sr_d  = tx_word[FRAME_BITS-2:0];
                    mosi_d   = tx_word[FRAME_BITS-1];
                    hp_cnt_d = '0;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], spi_miso_i};
                end
                // The final falling edge ends the frame, so MOSI keeps bit 0.
                if (sclk_fall && (hp_cnt_q != HpLast)) begin
                    mosi_d  = tx_sr_q[FRAME_BITS-2];
                    tx_sr_d = {tx_sr_q[FRAME_BITS-3:0], 1'b0};
                end
                if (tick) begin
                    hp_cnt_d = hp_cnt_q + 1'b1;
                    if (hp_cnt_q == HpLast) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d   = StGap;
                    mosi_d    = 1'b0;
                    rx_dv_d   = 1'b1;
                    rx_data_d = rx_sr_q;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        irq_pend_d = irq_pend_q;
        if (irq_take) begin
            irq_pend_d = 1'b0;
        end
        if (irq_edge) begin
            irq_pend_d = 1'b1;
        end
        if (!auto_en_i) begin
            irq_pend_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = (state_d != StIdle);
        cs_d   = !((state_d == StSetup) || (state_d == StXfer) || (state_d == StHold));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            hp_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            irq_sync1_q <= 1'b0;
            irq_sync2_q <= 1'b0;
            irq_prev_q  <= 1'b0;
            irq_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            hp_cnt_q    <= hp_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            irq_sync1_q <= irq_i;
            irq_sync2_q <= irq_sync1_q;
            irq_prev_q  <= irq_sync2_q;
            irq_pend_q  <= irq_pend_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            rx_dv_q     <= rx_dv_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign busy_o     = busy_q;
    assign rx_dv_o    = rx_dv_q;
    assign rx_data_o  = rx_data_q;
    assign spi_cs_o   = cs_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: randomised frames against a frame-level model (words in,
// words out, latency and spacing from the frame timing rules).
module tb_spi_master;

    localparam int DIV  = 4;
    localparam int GAP  = 2;
    localparam int DIV2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, auto_en = 1'b0, irq = 1'b0, miso;
    logic [31:0] tx_data = '0;
    logic        busy, rx_dv, sclk, cs, mosi;
    logic [31:0] rx_data;

    logic        start2 = 1'b0;
    logic [31:0] tx2 = '0;
    logic        busy2, rx_dv2, sclk2, cs2, mosi2;
    logic [31:0] rx_data2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    spi_master #(.CLK_DIV(DIV), .CS_GAP(GAP)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx_data),
        .auto_en_i(auto_en), .irq_i(irq), .busy_o(busy), .rx_dv_o(rx_dv),
        .rx_data_o(rx_data), .spi_sclk_o(sclk), .spi_cs_o(cs),
        .spi_mosi_o(mosi), .spi_miso_i(miso)
    );

    spi_master #(.CLK_DIV(DIV2), .CS_GAP(GAP)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .tx_data_i(tx2),
        .auto_en_i(1'b0), .irq_i(1'b0), .busy_o(busy2), .rx_dv_o(rx_dv2),
        .rx_data_o(rx_data2), .spi_sclk_o(sclk2), .spi_cs_o(cs2),
        .spi_mosi_o(mosi2), .spi_miso_i(mosi2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: latency and spacing in clk cycles, from the frame timing rules.
    function automatic int exp_latency(input int div);
        return 1 + (2 * 32 + 2) * div;
    endfunction

    // Slave model and bus monitor for dut, sampled mid-cycle.
    logic        cs_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;
    logic [31:0] slave_word = '0, slave_sr = '0, mosi_sr = '0;
    int          rise_cnt = 0, n_starts = 0, n_dv = 0, dv_cyc = 0, busy_fall_cyc = 0;
    int          start_cycs[$], rise_cycs[$];
    logic [31:0] got_mosi[$], got_rx[$];

    assign miso = slave_sr[31];

    always @(negedge clk) begin
        if (cs_prev && !cs) begin
            n_starts++;
            start_cycs.push_back(cyc);
            rise_cnt = 0;
            slave_sr = slave_word;
        end
        if (!cs_prev && cs) begin
            rise_cycs.push_back(cyc);
            if (rise_cnt == 32) got_mosi.push_back(mosi_sr);
        end
        if (!cs && !sclk_prev && sclk) begin
            mosi_sr = {mosi_sr[30:0], mosi};
            rise_cnt++;
        end
        if (!cs && sclk_prev && !sclk) slave_sr = slave_sr << 1;
        if (rx_dv) begin
            n_dv++;
            dv_cyc = cyc;
            got_rx.push_back(rx_data);
        end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        cs_prev   = cs;
        sclk_prev = sclk;
        busy_prev = busy;
    end

    logic        sclk2_prev = 1'b0;
    int          rise2_cycs[$];
    int          n_dv2 = 0, dv2_cyc = 0;
    logic [31:0] dv2_data = '0;

    always @(negedge clk) begin
        if (!sclk2_prev && sclk2) rise2_cycs.push_back(cyc);
        if (rx_dv2) begin
            n_dv2++;
            dv2_cyc  = cyc;
            dv2_data = rx_data2;
        end
        sclk2_prev = sclk2;
    end

    task automatic clear_logs();
        start_cycs.delete();
        rise_cycs.delete();
        got_mosi.delete();
        got_rx.delete();
    endtask

    // Drives a one-cycle start; caller is at a negedge. c0 is the acceptance cycle.
    task automatic issue_start(input logic [31:0] word, output int c0);
        tx_data = word;
        start   = 1'b1;
        c0      = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_dv(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (n_dv >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_bit(input int s0, input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (n_starts > s0 && rise_cnt >= k) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        repeat (2) @(negedge clk);
        irq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", cs); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rx_dv !== 1'b0) begin failures++; $display("FAIL reset_rx_dv got=%b exp=0", rx_dv); end
        checks++;
        if (rx_data !== 32'h0) begin
            failures++; $display("FAIL reset_rx_data got=%h exp=00000000", rx_data);
        end
        checks++; if (cs2 !== 1'b1) begin failures++; $display("FAIL reset_cs2 got=%b exp=1", cs2); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed_frame();
        int c0, d0;
        bit ok;
        logic [31:0] w;
        clear_logs();
        d0 = n_dv;
        slave_word = 32'hA5A5_0F0F;
        issue_start(32'h8000_1234, c0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dir_busy_on got=%b exp=1", busy); end
        checks++; if (cs !== 1'b0) begin failures++; $display("FAIL dir_cs_low got=%b exp=0", cs); end
        checks++; if (mosi !== 1'b1) begin failures++; $display("FAIL dir_mosi_b31 got=%b exp=1", mosi); end
        wait_dv(d0 + 1, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dir_dv_timeout got=none exp=pulse"); end
        wait_idle(50, ok);
        repeat (5) @(negedge clk);
        w = (got_mosi.size() > 0) ? got_mosi[0] : 32'hx;
        checks++; if (w !== 32'h8000_1234) begin failures++; $display("FAIL dir_mosi got=%h exp=80001234", w); end
        checks++;
        if (rx_data !== 32'hA5A5_0F0F) begin
            failures++; $display("FAIL dir_rx_data got=%h exp=a5a50f0f", rx_data);
        end
        checks++; if (n_dv - d0 !== 1) begin failures++; $display("FAIL dir_dv_count got=%0d exp=1", n_dv - d0); end
        checks++;
        if (dv_cyc - c0 !== exp_latency(DIV)) begin
            failures++; $display("FAIL dir_latency got=%0d exp=%0d", dv_cyc - c0, exp_latency(DIV));
        end
        checks++;
        if (busy_fall_cyc - c0 !== exp_latency(DIV) + GAP) begin
            failures++;
            $display("FAIL dir_busy_fall got=%0d exp=%0d", busy_fall_cyc - c0, exp_latency(DIV) + GAP);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_tx[$], exp_rx[$];
        logic [31:0] w;
        int c0, d0;
        bit ok;
        clear_logs();
        d0 = n_dv;
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back($urandom);
            exp_rx.push_back($urandom);
            wait_idle(400, ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_idle_timeout frame=%0d", i); end
            slave_word = exp_rx[i];
            issue_start(exp_tx[i], c0);
        end
        wait_dv(d0 + 4, 400, ok);
        wait_idle(50, ok);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w = (got_mosi.size() > i) ? got_mosi[i] : 32'hx;
            checks++;
            if (w !== exp_tx[i]) begin
                failures++; $display("FAIL b2b_mosi[%0d] got=%h exp=%h", i, w, exp_tx[i]);
            end
            w = (got_rx.size() > i) ? got_rx[i] : 32'hx;
            checks++;
            if (w !== exp_rx[i]) begin
                failures++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, w, exp_rx[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            c0 = (start_cycs.size() > i + 1 && rise_cycs.size() > i) ?
                 start_cycs[i+1] - rise_cycs[i] : -1;
            checks++;
            if (c0 !== GAP + 1) begin
                failures++; $display("FAIL b2b_cs_gap[%0d] got=%0d exp=%0d", i, c0, GAP + 1);
            end
        end
    endtask

    task automatic test_irq_auto();
        int t0, d0, dt;
        bit ok;
        logic [31:0] w;
        clear_logs();
        d0 = n_dv;
        slave_word = $urandom;
        auto_en = 1'b1;
        @(negedge clk);
        t0 = cyc;
        pulse_irq();
        wait_dv(d0 + 1, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL irq_dv_timeout got=none exp=pulse"); end
        wait_idle(50, ok);
        repeat (20) @(negedge clk);
        dt = (start_cycs.size() > 0) ? start_cycs[0] - t0 : 9999;
        checks++; if (dt > 4) begin failures++; $display("FAIL irq_start_delay got=%0d exp<=4", dt); end
        checks++;
        if (start_cycs.size() !== 1) begin
            failures++; $display("FAIL irq_frames got=%0d exp=1", start_cycs.size());
        end
        w = (got_mosi.size() > 0) ? got_mosi[0] : 32'hx;
        checks++; if (w !== 32'h0) begin failures++; $display("FAIL irq_mosi got=%h exp=00000000", w); end
        checks++;
        if (rx_data !== slave_word) begin
            failures++; $display("FAIL irq_rx got=%h exp=%h", rx_data, slave_word);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_irq_during_frame();
        logic [31:0] tx;
        logic [31:0] w;
        int c0, s0, d0, gap;
        bit ok;
        clear_logs();
        s0 = n_starts;
        d0 = n_dv;
        tx = $urandom;
        slave_word = $urandom;
        auto_en = 1'b1;
        issue_start(tx, c0);
        wait_bit(s0, 5, ok);
        pulse_irq();
        wait_bit(s0, 15, ok);
        pulse_irq();
        wait_dv(d0 + 2, 800, ok);
        checks++; if (!ok) begin failures++; $display("FAIL irqf_dv_timeout got=%0d exp=2", n_dv - d0); end
        wait_idle(50, ok);
        repeat (30) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 2) begin
            failures++; $display("FAIL irqf_frames got=%0d exp=2", n_starts - s0);
        end
        w = (got_mosi.size() > 0) ? got_mosi[0] : 32'hx;
        checks++; if (w !== tx) begin failures++; $display("FAIL irqf_mosi0 got=%h exp=%h", w, tx); end
        w = (got_mosi.size() > 1) ? got_mosi[1] : 32'hx;
        checks++; if (w !== 32'h0) begin failures++; $display("FAIL irqf_mosi1 got=%h exp=00000000", w); end
        gap = (start_cycs.size() > 1 && rise_cycs.size() > 0) ? start_cycs[1] - rise_cycs[0] : -1;
        checks++;
        if (gap !== GAP + 1) begin
            failures++; $display("FAIL irqf_restart got=%0d exp=%0d", gap, GAP + 1);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_start_rules();
        logic [31:0] tx1, txa, txb, w;
        logic [31:0] exp_tx[$];
        int c0, s0, d0;
        bit ok;
        clear_logs();
        s0 = n_starts;
        tx1 = $urandom;
        issue_start(tx1, c0);
        wait_bit(s0, 10, ok);
        tx_data = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(400, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 1) begin
            failures++; $display("FAIL busy_start_frames got=%0d exp=1", n_starts - s0);
        end
        w = (got_mosi.size() > 0) ? got_mosi[0] : 32'hx;
        checks++; if (w !== tx1) begin failures++; $display("FAIL busy_start_mosi got=%h exp=%h", w, tx1); end

        // start_i in the same IDLE cycle as a pending irq: start frame first, then irq frame.
        clear_logs();
        s0 = n_starts;
        d0 = n_dv;
        auto_en = 1'b1;
        txa = $urandom;
        txb = $urandom | 32'h1;
        exp_tx = '{txa, txb, 32'h0};
        issue_start(txa, c0);
        wait_bit(s0, 5, ok);
        pulse_irq();
        wait_idle(400, ok);
        issue_start(txb, c0);
        wait_dv(d0 + 3, 1200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_dv_timeout got=%0d exp=3", n_dv - d0); end
        wait_idle(50, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 3) begin
            failures++; $display("FAIL prio_frames got=%0d exp=3", n_starts - s0);
        end
        for (int i = 0; i < 3; i++) begin
            w = (got_mosi.size() > i) ? got_mosi[i] : 32'hx;
            checks++;
            if (w !== exp_tx[i]) begin
                failures++; $display("FAIL prio_mosi[%0d] got=%h exp=%h", i, w, exp_tx[i]);
            end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_auto_en_clear();
        int c0, s0;
        bit ok;
        clear_logs();
        s0 = n_starts;
        auto_en = 1'b1;
        issue_start($urandom, c0);
        wait_bit(s0, 5, ok);
        pulse_irq();
        repeat (4) @(negedge clk);
        auto_en = 1'b0;
        wait_idle(400, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 1) begin
            failures++; $display("FAIL auto_clear_frames got=%0d exp=1", n_starts - s0);
        end
        pulse_irq();
        repeat (20) @(negedge clk);
        checks++;
        if (n_starts - s0 !== 1) begin
            failures++; $display("FAIL auto_off_irq got=%0d exp=1", n_starts - s0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0, s0, d0;
        bit ok;
        s0 = n_starts;
        issue_start($urandom, c0);
        wait_bit(s0, 10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_bit10_timeout got=none exp=bit10"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL rstmid_cs got=%b exp=1", cs); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rstmid_sclk got=%b exp=0", sclk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rst = 1'b0;
        d0 = n_dv;
        repeat (400) @(negedge clk);
        checks++; if (n_dv !== d0) begin failures++; $display("FAIL rstmid_dv got=%0d exp=0", n_dv - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_clkdiv2();
        logic [31:0] words[2];
        int c0, d0, per;
        bit ok;
        words[0] = 32'hFFFF_FFFF;
        words[1] = $urandom;
        for (int k = 0; k < 2; k++) begin
            rise2_cycs.delete();
            d0 = n_dv2;
            tx2 = words[k];
            start2 = 1'b1;
            c0 = cyc;
            @(negedge clk);
            start2 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (n_dv2 > d0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checks++; if (!ok) begin failures++; $display("FAIL div2_dv_timeout[%0d]", k); end
            per = (rise2_cycs.size() > 1) ? rise2_cycs[1] - rise2_cycs[0] : -1;
            checks++;
            if (per !== 2 * DIV2) begin
                failures++; $display("FAIL div2_period[%0d] got=%0d exp=%0d", k, per, 2 * DIV2);
            end
            checks++;
            if (rise2_cycs.size() !== 32) begin
                failures++; $display("FAIL div2_rises[%0d] got=%0d exp=32", k, rise2_cycs.size());
            end
            checks++;
            if (dv2_data !== words[k]) begin
                failures++; $display("FAIL div2_loopback[%0d] got=%h exp=%h", k, dv2_data, words[k]);
            end
            checks++;
            if (dv2_cyc - c0 !== exp_latency(DIV2)) begin
                failures++;
                $display("FAIL div2_latency[%0d] got=%0d exp=%0d", k, dv2_cyc - c0, exp_latency(DIV2));
            end
            for (int i = 0; i < 20 && busy2 !== 1'b0; i++) @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_back_to_back();
        test_irq_auto();
        test_irq_during_frame();
        test_start_rules();
        test_auto_en_clear();
        test_reset_mid_frame();
        test_clkdiv2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, sets the SCLK half-period in clk_i cycles; legal values are 2 or more.
REQ-002 Parameter CS_GAP, default 2, sets the number of clk_i cycles spi_cs_o is held high between frames.
REQ-003 The block SHALL use one clock, clk_i, and a synchronous active-high reset, rst_i.
REQ-004 clk_i  in  1  system clock.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 start_i  in  1  one-cycle request to start a frame.
REQ-007 tx_data_i  in  32  word to shift out; captured when a frame is accepted.
REQ-008 auto_en_i  in  1  enables frames started by irq_i.
REQ-009 irq_i  in  1  slave interrupt (slave o_RX_DV); asynchronous to clk_i.
REQ-010 busy_o  out  1  high from frame acceptance through the end of the CS gap.
REQ-011 rx_dv_o  out  1  one-cycle pulse; rx_data_o is valid.
REQ-012 rx_data_o  out  32  last received word, held until the next rx_dv_o pulse.
REQ-013 spi_sclk_o  out  1; spi_cs_o  out  1 (active-low); spi_mosi_o  out  1; spi_miso_i  in  1.

Function
REQ-014 SPI mode 0 SHALL be used: SCLK idles low; MISO is sampled on the cycle SCLK rises; MOSI changes on the cycle SCLK falls; frames are 32 bits, MSB first.
REQ-015 The FSM SHALL have the states IDLE, SETUP, XFER, HOLD and GAP.
- IDLE->SETUP on an accepted request.
- SETUP->XFER after CLK_DIV cycles.
- XFER->HOLD after 64 half-periods.
- HOLD->GAP after CLK_DIV cycles.
- GAP->IDLE after CS_GAP cycles.
REQ-016 Accepting a request in IDLE SHALL do the following:
- capture the word into the shift register;
- assert busy_o and drive spi_cs_o low on the next cycle;
- drive spi_mosi_o with bit 31 during SETUP.
REQ-017 In XFER, spi_sclk_o SHALL toggle every CLK_DIV cycles, giving 32 rising edges.
REQ-018 On each falling edge except the last, spi_mosi_o SHALL advance to the next lower bit.
REQ-019 On each rising edge, spi_miso_i SHALL be shifted into the LSB of the receive register.
REQ-020 When entering GAP, the block SHALL do the following in the same cycle:
- drive spi_cs_o high;
- drive spi_mosi_o low;
- load rx_data_o;
- pulse rx_dv_o.
REQ-021 busy_o SHALL fall on the cycle the FSM re-enters IDLE.
- Frame length from acceptance to rx_dv_o: 1 + 66*CLK_DIV cycles.
REQ-022 irq_i SHALL pass through a 2-flop synchronizer followed by rising-edge detection.
REQ-023 An irq edge with auto_en_i=1 SHALL set irq_pending.
REQ-024 In IDLE with irq_pending set and start_i low, the block SHALL start a frame with tx word 0x0000_0000 and clear irq_pending.
REQ-025 If start_i and irq_pending occur together in IDLE, start_i SHALL win and irq_pending SHALL stay set; it is serviced after GAP.
REQ-026 start_i while busy_o=1 SHALL be ignored and not queued.
REQ-027 irq edges while busy SHALL set irq_pending; at most one is queued, and further edges are merged.
REQ-028 Clearing auto_en_i SHALL clear irq_pending on the next cycle.

Reset
REQ-029 While rst_i=1, the following SHALL hold on the next clock edge:
- state is IDLE;
- spi_cs_o=1, spi_sclk_o=0, spi_mosi_o=0;
- busy_o=0, rx_dv_o=0;
- rx_data_o=0;
- irq_pending and the synchronizer flops are 0.
REQ-030 A reset mid-frame SHALL abort the frame: spi_cs_o goes high on the next cycle and no rx_dv_o pulse is produced.

Structure
REQ-031 The shared package voltmeter_spi_pkg SHALL hold:
- the FSM state enum;
- FRAME_BITS=32;
- the status-word field offsets: count[15:0], comp 16, sat_hi 17, sat_lo 18, ref_ok 19, afe_sel[21:20], range_sel[24:22], afe_reset 25, ref_sign 26, range_error 27, done 28, counter_done 29, counter_en 30, override 31.
REQ-032 One sub-module, spi_sclk_div, SHALL generate the half-period tick and the rise/fall strobes.

Verification
REQ-033 Directed scenarios, run with CLK_DIV=4 and CS_GAP=2 unless stated:
- start_i with tx_data_i=0x8000_1234 and a slave model returning 0xA5A5_0F0F -> MOSI carries 0x80001234 MSB first, rx_data_o=0xA5A50F0F, one rx_dv_o pulse 265 cycles after acceptance.
- auto_en_i=1 and an irq_i pulse -> a frame starts within 4 cycles with MOSI all zero.
- irq_i pulsed at bit 5 of a start_i frame -> a second frame starts exactly CS_GAP+1 cycles after spi_cs_o rises.
- start_i pulsed at bit 10 -> ignored, only one frame; start_i coincident with a pending irq -> the start_i frame runs, then the irq frame.
- rst_i asserted at bit 10 -> spi_cs_o=1 and spi_sclk_o=0 on the next cycle, no rx_dv_o pulse, busy_o=0.
- CLK_DIV=2 -> SCLK period is 4 cycles and a 0xFFFF_FFFF loopback (MISO tied to MOSI) gives rx_data_o=0xFFFF_FFFF.
